// File: rtl/z88_pkg.sv
// ============================================================================
// Module  : z88_pkg
// Purpose : Shared types and constants for the Z88 external memory arbiter:
//           slot sequencer state encoding, requester owner codes and the
//           address-prefix constants used by the decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package z88_pkg;

   // Slot sequencer states; one access walks SETUP..RECOV then returns to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RECOV   = 3'd4
   } slot_state_t;

   // Which requester owns the access in flight.
   typedef enum logic [1:0] {
      OWN_CPU = 2'd0,
      OWN_LCD = 2'd1,
      OWN_LDR = 2'd2
   } owner_t;

   // Physical address prefixes (addr[21:19] for internal, addr[21:20] for cards).
   localparam logic [2:0] c_ROM_PREFIX  = 3'b000;
   localparam logic [2:0] c_RAM_PREFIX  = 3'b001;
   localparam logic [1:0] c_EXT1_PREFIX = 2'b01;
   localparam logic [1:0] c_EXT2_PREFIX = 2'b10;
   localparam logic [1:0] c_EXT3_PREFIX = 2'b11;

   // Byte-lane enables: odd bytes live on [15:8], even bytes on [7:0].
   function automatic logic [1:0] lane_be_n(input logic odd);
      return odd ? 2'b01 : 2'b10;
   endfunction

endpackage

`default_nettype wire

// File: rtl/z88_mem_decode.sv
// ============================================================================
// Module  : z88_mem_decode
// Purpose : Combinational decode of a 22-bit physical byte address into chip
//           selects, byte-lane enables and the 16-bit word address.
// Ports   : addr      in  22  physical byte address
//           rom_sel   out 1   internal ROM selected
//           ram_sel   out 1   internal RAM selected
//           ext_sel   out 3   card slot 1-3 selected (active-high)
//           be_n      out 2   byte-lane enables (active-low)
//           word_addr out 19  word address, RAM offset masked
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z88_mem_decode
   import z88_pkg::*;
#(
   parameter logic [18:0] RAM_ADDR_MASK = 19'h07FFF
) (
   input  logic [21:0] addr,
   output logic        rom_sel,
   output logic        ram_sel,
   output logic [3:1]  ext_sel,
   output logic [1:0]  be_n,
   output logic [18:0] word_addr
);

   always_comb begin
      rom_sel    = (addr[21:19] == c_ROM_PREFIX);
      ram_sel    = (addr[21:19] == c_RAM_PREFIX);
      ext_sel[1] = (addr[21:20] == c_EXT1_PREFIX);
      ext_sel[2] = (addr[21:20] == c_EXT2_PREFIX);
      ext_sel[3] = (addr[21:20] == c_EXT3_PREFIX);
      be_n       = lane_be_n(addr[0]);
      // RAM smaller than its 512 KB window aliases (wraps) via the mask.
      if (ram_sel) begin
         word_addr = {1'b0, addr[18:1] & RAM_ADDR_MASK[18:1]};
      end else begin
         word_addr = {1'b0, addr[18:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/z88_mem_arb.sv
// ============================================================================
// Module  : z88_mem_arb
// Purpose : Time-slot arbiter and access sequencer for the shared external
//           memory bus (internal ROM/RAM and card slots 1-3). The slot owner
//           (CPU when bus_ph=1, LCD when bus_ph=0) is granted at slot_ena;
//           the host loader fills slots its owner leaves unused.
// Ports   : clk, rst (sync, active-high), slot_ena, bus_ph
//           cpu_req/we/addr/wdata in, cpu_rdata/cpu_ack out
//           lcd_req/lcd_addr in, lcd_rdata/lcd_vld out
//           ldr_req/we/addr/wdata in, ldr_rdata/ldr_ack out
//           rom_ce_n, ram_ce_n, ext_cs_n[3:1], mem_oe_n, mem_we_n,
//           mem_be_n[1:0], mem_addr[18:0], mem_wdata[15:0] out
//           ram_rdata[15:0], rom_rdata[15:0] in
// Config  : Z88_ARB_LDR_EN - when defined the loader port is active;
//           otherwise ldr_ack/ldr_rdata are tied low and ldr_* is ignored.
// Timing  : ack/vld is high in the 3rd clock after the slot_ena clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z88_mem_arb
   import z88_pkg::*;
#(
   parameter logic [18:0] RAM_ADDR_MASK = 19'h07FFF,
   parameter logic [7:0]  EXT_RD_VAL    = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        slot_ena,
   input  logic        bus_ph,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [21:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        lcd_req,
   input  logic [21:0] lcd_addr,
   output logic [7:0]  lcd_rdata,
   output logic        lcd_vld,
   input  logic        ldr_req,
   input  logic        ldr_we,
   input  logic [21:0] ldr_addr,
   input  logic [7:0]  ldr_wdata,
   output logic [7:0]  ldr_rdata,
   output logic        ldr_ack,
   output logic        rom_ce_n,
   output logic        ram_ce_n,
   output logic [3:1]  ext_cs_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic [1:0]  mem_be_n,
   output logic [18:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] ram_rdata,
   input  logic [15:0] rom_rdata
);

   slot_state_t r_state, w_state_nxt;
   owner_t      w_own, r_own;
   logic        w_grant, w_ldr_go;
   logic [21:0] w_sel_addr;
   logic        w_sel_we;
   logic [7:0]  w_sel_wd;
   logic        w_rom, w_ram;
   logic [3:1]  w_ext;
   logic [1:0]  w_be_n;
   logic [18:0] w_word;
   logic        r_we, r_rom, r_ext, r_odd;
   logic [7:0]  w_rd_byte;

`ifdef Z88_ARB_LDR_EN
   assign w_ldr_go = ldr_req;
`else
   assign w_ldr_go = 1'b0;
   logic w_unused_ldr;
   assign w_unused_ldr = ldr_req;
`endif

   // Owner first, loader only backfills a slot the owner does not claim.
   always_comb begin
      w_grant    = 1'b1;
      w_own      = OWN_CPU;
      if (bus_ph && cpu_req) begin
         w_own = OWN_CPU;
      end else if (!bus_ph && lcd_req) begin
         w_own = OWN_LCD;
      end else if (w_ldr_go) begin
         w_own = OWN_LDR;
      end else begin
         w_grant = 1'b0;
      end
      case (w_own)
         OWN_LCD: begin
            w_sel_addr = lcd_addr;
            w_sel_we   = 1'b0;
            w_sel_wd   = 8'h00;
         end
         OWN_LDR: begin
            w_sel_addr = ldr_addr;
            w_sel_we   = ldr_we;
            w_sel_wd   = ldr_wdata;
         end
         default: begin
            w_sel_addr = cpu_addr;
            w_sel_we   = cpu_we;
            w_sel_wd   = cpu_wdata;
         end
      endcase
   end

   z88_mem_decode #(
      .RAM_ADDR_MASK (RAM_ADDR_MASK)
   ) u_decode (
      .addr      (w_sel_addr),
      .rom_sel   (w_rom),
      .ram_sel   (w_ram),
      .ext_sel   (w_ext),
      .be_n      (w_be_n),
      .word_addr (w_word)
   );

   // Slot sequencer: slot_ena is only honoured in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (slot_ena && w_grant) w_state_nxt = ST_SETUP;
         ST_SETUP:   w_state_nxt = ST_STROBE;
         ST_STROBE:  w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = ST_RECOV;
         ST_RECOV:   w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Read byte for the latched target, sampled at the end of STROBE.
   always_comb begin
      w_rd_byte = r_odd ? ram_rdata[15:8] : ram_rdata[7:0];
      if (r_rom) w_rd_byte = r_odd ? rom_rdata[15:8] : rom_rdata[7:0];
      if (r_ext) w_rd_byte = EXT_RD_VAL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_ce_n  <= 1'b1;
         ram_ce_n  <= 1'b1;
         ext_cs_n  <= 3'b111;
         mem_oe_n  <= 1'b1;
         mem_we_n  <= 1'b1;
         mem_be_n  <= 2'b11;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         lcd_vld   <= 1'b0;
         lcd_rdata <= '0;
         r_own     <= OWN_CPU;
         r_we      <= 1'b0;
         r_rom     <= 1'b0;
         r_ext     <= 1'b0;
         r_odd     <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         lcd_vld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (slot_ena && w_grant) begin
                  r_own     <= w_own;
                  r_we      <= w_sel_we;
                  r_rom     <= w_rom;
                  r_ext     <= |w_ext;
                  r_odd     <= w_sel_addr[0];
                  mem_addr  <= w_word;
                  mem_be_n  <= w_be_n;
                  mem_wdata <= {w_sel_wd, w_sel_wd};
                  // ROM writes are acknowledged but never reach the device.
                  rom_ce_n  <= !(w_rom && !w_sel_we);
                  ram_ce_n  <= !w_ram;
                  ext_cs_n  <= ~w_ext;
               end
            end
            ST_SETUP: begin
               mem_oe_n <= r_we;
               mem_we_n <= !(r_we && !r_rom);
            end
            ST_STROBE: begin
               mem_we_n <= 1'b1;
               case (r_own)
                  OWN_CPU: begin
                     cpu_ack <= 1'b1;
                     if (!r_we) cpu_rdata <= w_rd_byte;
                  end
                  OWN_LCD: begin
                     lcd_vld   <= 1'b1;
                     lcd_rdata <= w_rd_byte;
                  end
                  default: ;
               endcase
            end
            ST_CAPTURE: begin
               rom_ce_n <= 1'b1;
               ram_ce_n <= 1'b1;
               ext_cs_n <= 3'b111;
               mem_oe_n <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef Z88_ARB_LDR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ldr_ack   <= 1'b0;
         ldr_rdata <= '0;
      end else begin
         ldr_ack <= 1'b0;
         if (r_state == ST_STROBE && r_own == OWN_LDR) begin
            ldr_ack <= 1'b1;
            if (!r_we) ldr_rdata <= w_rd_byte;
         end
      end
   end
`else
   assign ldr_ack   = 1'b0;
   assign ldr_rdata = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_z88_mem_arb.sv
// ============================================================================
// Module  : tb_z88_mem_arb
// Purpose : Self-checking bench for z88_mem_arb: directed vector table,
//           multi-cycle corner sequences and randomized slots checked
//           against a behavioural address-map model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z88_mem_arb;

`ifdef Z88_ARB_LDR_EN
   localparam bit LDR_EN = 1'b1;
`else
   localparam bit LDR_EN = 1'b0;
`endif
   localparam int         c_RAM_BYTES = 32'h8000;
   localparam logic [7:0] c_EXT_VAL   = 8'h00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        slot_ena = 1'b0, bus_ph = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [21:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        lcd_req = 1'b0;
   logic [21:0] lcd_addr = '0;
   logic [7:0]  lcd_rdata;
   logic        lcd_vld;
   logic        ldr_req = 1'b0, ldr_we = 1'b0;
   logic [21:0] ldr_addr = '0;
   logic [7:0]  ldr_wdata = '0;
   logic [7:0]  ldr_rdata;
   logic        ldr_ack;
   logic        rom_ce_n, ram_ce_n, mem_oe_n, mem_we_n;
   logic [3:1]  ext_cs_n;
   logic [1:0]  mem_be_n;
   logic [18:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] ram_rdata = '0, rom_rdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   z88_mem_arb dut (
      .clk(clk), .rst(rst), .slot_ena(slot_ena), .bus_ph(bus_ph),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_rdata(lcd_rdata), .lcd_vld(lcd_vld),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
      .rom_ce_n(rom_ce_n), .ram_ce_n(ram_ce_n), .ext_cs_n(ext_cs_n),
      .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_be_n(mem_be_n),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .ram_rdata(ram_rdata), .rom_rdata(rom_rdata)
   );

   typedef struct {
      bit          ph, creq, cwe, lreq, dreq, dwe;
      logic [21:0] caddr, laddr, daddr;
      logic [7:0]  cwd, dwd;
      logic [15:0] romd, ramd;
   } stim_t;

   // who: 0 none, 1 CPU, 2 LCD, 3 loader. *_lo: cycles the strobe is low.
   typedef struct {
      int          who;
      bit          rd;
      logic [7:0]  rdata;
      int          rom_lo, ram_lo, ext_lo, we_lo, oe_lo;
      logic [2:0]  ext_val;
      bit          bus, chk_wd;
      logic [1:0]  be;
      logic [18:0] maddr;
      logic [15:0] wd;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic stim_t mk_st(bit ph, bit creq, bit cwe, logic [21:0] caddr, logic [7:0] cwd,
                                   bit lreq, logic [21:0] laddr, bit dreq, bit dwe,
                                   logic [21:0] daddr, logic [7:0] dwd,
                                   logic [15:0] romd, logic [15:0] ramd);
      stim_t s;
      s.ph = ph; s.creq = creq; s.cwe = cwe; s.caddr = caddr; s.cwd = cwd;
      s.lreq = lreq; s.laddr = laddr; s.dreq = dreq; s.dwe = dwe;
      s.daddr = daddr; s.dwd = dwd; s.romd = romd; s.ramd = ramd;
      return s;
   endfunction

   function automatic exp_t mk_ex(int who, bit rd, logic [7:0] rdata, int rom_lo, int ram_lo,
                                  int ext_lo, logic [2:0] ext_val, int we_lo, int oe_lo,
                                  bit bus, logic [1:0] be, logic [18:0] maddr,
                                  bit chk_wd, logic [15:0] wd);
      exp_t e;
      e.who = who; e.rd = rd; e.rdata = rdata; e.rom_lo = rom_lo; e.ram_lo = ram_lo;
      e.ext_lo = ext_lo; e.ext_val = ext_val; e.we_lo = we_lo; e.oe_lo = oe_lo;
      e.bus = bus; e.be = be; e.maddr = maddr; e.chk_wd = chk_wd; e.wd = wd;
      return e;
   endfunction

   // Behavioural model: memory map and lane rules in plain arithmetic.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      logic [21:0] a;
      bit          we;
      logic [7:0]  wd;
      int          slot, off;
      e = mk_ex(0, 0, 8'h00, 0, 0, 0, 3'b111, 0, 0, 0, 2'b11, 19'h0, 0, 16'h0);
      if (s.ph && s.creq) begin
         e.who = 1; a = s.caddr; we = s.cwe; wd = s.cwd;
      end else if (!s.ph && s.lreq) begin
         e.who = 2; a = s.laddr; we = 1'b0; wd = 8'h00;
      end else if (LDR_EN && s.dreq) begin
         e.who = 3; a = s.daddr; we = s.dwe; wd = s.dwd;
      end else begin
         return e;
      end
      e.be     = (int'(a) % 2 == 1) ? 2'b01 : 2'b10;
      e.wd     = {wd, wd};
      e.chk_wd = we;
      slot     = int'(a) / 32'h100000;
      if (slot != 0) begin
         e.ext_lo  = 3;
         e.ext_val = ~(3'b001 << (slot - 1));
         e.maddr   = 19'((int'(a) % 32'h80000) / 2);
         e.bus     = 1'b1;
         if (we) e.we_lo = 1;
         else begin e.oe_lo = 2; e.rd = 1'b1; e.rdata = c_EXT_VAL; end
      end else if (int'(a) < 32'h80000) begin
         if (!we) begin
            e.rom_lo = 3; e.oe_lo = 2; e.rd = 1'b1; e.bus = 1'b1;
            e.rdata  = 8'(s.romd >> (8 * (int'(a) % 2)));
            e.maddr  = 19'(int'(a) / 2);
         end
      end else begin
         off      = (int'(a) - 32'h80000) % c_RAM_BYTES;
         e.ram_lo = 3;
         e.bus    = 1'b1;
         e.maddr  = 19'(off / 2);
         if (we) e.we_lo = 1;
         else begin
            e.oe_lo = 2; e.rd = 1'b1;
            e.rdata = 8'(s.ramd >> (8 * (int'(a) % 2)));
         end
      end
      return e;
   endfunction

   function automatic logic [21:0] rand_addr();
      int r;
      r = $urandom_range(0, 4);
      case (r)
         0:       return 22'($urandom & 32'h7FFFF);
         1:       return 22'(32'h80000 | ($urandom & 32'h7FFFF));
         default: return 22'(((r - 1) << 20) | ($urandom & 32'hFFFFF));
      endcase
   endfunction

   task automatic run_slot(input stim_t s, input exp_t e, input string tag);
      int          rom_lo = 0, ram_lo = 0, ext_lo = 0, we_lo = 0, oe_lo = 0;
      logic [4:0]  cp = '0, lp = '0, dp = '0;
      logic [7:0]  rdv = '0;
      logic [2:0]  ext1 = '0;
      logic [1:0]  be2 = '0;
      logic [18:0] ma2 = '0;
      logic [15:0] wd2 = '0;
      @(posedge clk); #1;
      bus_ph = s.ph; cpu_req = s.creq; cpu_we = s.cwe; cpu_addr = s.caddr; cpu_wdata = s.cwd;
      lcd_req = s.lreq; lcd_addr = s.laddr;
      ldr_req = s.dreq; ldr_we = s.dwe; ldr_addr = s.daddr; ldr_wdata = s.dwd;
      rom_rdata = s.romd; ram_rdata = s.ramd;
      slot_ena = 1'b1;
      @(posedge clk); #1;
      slot_ena = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         rom_lo += int'(!rom_ce_n);
         ram_lo += int'(!ram_ce_n);
         ext_lo += int'(ext_cs_n != 3'b111);
         we_lo  += int'(!mem_we_n);
         oe_lo  += int'(!mem_oe_n);
         cp[k-1] = cpu_ack; lp[k-1] = lcd_vld; dp[k-1] = ldr_ack;
         if (k == 1) ext1 = ext_cs_n;
         if (k == 2) begin be2 = mem_be_n; ma2 = mem_addr; wd2 = mem_wdata; end
         if (k == 3) rdv = (e.who == 2) ? lcd_rdata : (e.who == 3) ? ldr_rdata : cpu_rdata;
      end
      cpu_req = 1'b0; lcd_req = 1'b0; ldr_req = 1'b0;
      chk({tag, " cpu_ack"}, 32'(cp), (e.who == 1) ? 32'h4 : 32'h0);
      chk({tag, " lcd_vld"}, 32'(lp), (e.who == 2) ? 32'h4 : 32'h0);
      chk({tag, " ldr_ack"}, 32'(dp), (e.who == 3) ? 32'h4 : 32'h0);
      chk({tag, " rom_ce_n low cycles"}, rom_lo, e.rom_lo);
      chk({tag, " ram_ce_n low cycles"}, ram_lo, e.ram_lo);
      chk({tag, " ext_cs_n low cycles"}, ext_lo, e.ext_lo);
      chk({tag, " ext_cs_n"}, 32'(ext1), 32'(e.ext_val));
      chk({tag, " we_n low cycles"}, we_lo, e.we_lo);
      chk({tag, " oe_n low cycles"}, oe_lo, e.oe_lo);
      if (e.rd) chk({tag, " rdata"}, 32'(rdv), 32'(e.rdata));
      if (e.bus) begin
         chk({tag, " be_n"}, 32'(be2), 32'(e.be));
         chk({tag, " mem_addr"}, 32'(ma2), 32'(e.maddr));
         if (e.chk_wd) chk({tag, " mem_wdata"}, 32'(wd2), 32'(e.wd));
      end
   endtask

   vec_t vt[12];

   initial begin
      int         acks;
      logic [7:0] ack_pat;
      stim_t      s;

      vt[0]  = '{mk_st(1,1,0,22'h000003,8'h00,0,0,0,0,0,8'h00,16'hA55A,16'h0000),
                 mk_ex(1,1,8'hA5,3,0,0,3'b111,0,2,1,2'b01,19'h00001,0,16'h0)};
      vt[1]  = '{mk_st(1,1,1,22'h080010,8'h3C,0,0,0,0,0,8'h00,16'h0000,16'h0000),
                 mk_ex(1,0,8'h00,0,3,0,3'b111,1,0,1,2'b10,19'h00008,1,16'h3C3C)};
      vt[2]  = '{mk_st(0,0,0,22'h000000,8'h00,0,0,1,1,22'h080001,8'h5A,16'h0,16'h0),
                 LDR_EN ? mk_ex(3,0,8'h00,0,3,0,3'b111,1,0,1,2'b01,19'h00000,1,16'h5A5A)
                        : mk_ex(0,0,8'h00,0,0,0,3'b111,0,0,0,2'b11,19'h0,0,16'h0)};
      vt[3]  = '{mk_st(1,1,1,22'h000100,8'h44,0,0,0,0,0,8'h00,16'h0000,16'h0000),
                 mk_ex(1,0,8'h00,0,0,0,3'b111,0,0,0,2'b11,19'h0,0,16'h0)};
      vt[4]  = '{mk_st(1,1,0,22'h100000,8'h00,0,0,0,0,0,8'h00,16'hFFFF,16'hFFFF),
                 mk_ex(1,1,8'h00,0,0,3,3'b110,0,2,1,2'b10,19'h00000,0,16'h0)};
      vt[5]  = '{mk_st(1,1,0,22'h088001,8'h00,0,0,0,0,0,8'h00,16'h0000,16'hBEEF),
                 mk_ex(1,1,8'hBE,0,3,0,3'b111,0,2,1,2'b01,19'h00000,0,16'h0)};
      vt[6]  = '{mk_st(0,0,0,22'h000000,8'h00,1,22'h080005,0,0,0,8'h00,16'h0,16'h1234),
                 mk_ex(2,1,8'h12,0,3,0,3'b111,0,2,1,2'b01,19'h00002,0,16'h0)};
      vt[7]  = '{mk_st(1,0,0,22'h000000,8'h00,1,22'h080005,0,0,0,8'h00,16'h0,16'h0),
                 mk_ex(0,0,8'h00,0,0,0,3'b111,0,0,0,2'b11,19'h0,0,16'h0)};
      vt[8]  = '{mk_st(0,1,0,22'h000003,8'h00,0,0,0,0,0,8'h00,16'h0,16'h0),
                 mk_ex(0,0,8'h00,0,0,0,3'b111,0,0,0,2'b11,19'h0,0,16'h0)};
      vt[9]  = '{mk_st(1,1,1,22'h3FFFFE,8'h77,0,0,0,0,0,8'h00,16'h0,16'h0),
                 mk_ex(1,0,8'h00,0,0,3,3'b011,1,0,1,2'b10,19'h3FFFF,1,16'h7777)};
      vt[10] = '{mk_st(1,1,0,22'h07FFFE,8'h00,0,0,0,0,0,8'h00,16'h1234,16'h0),
                 mk_ex(1,1,8'h34,3,0,0,3'b111,0,2,1,2'b10,19'h3FFFF,0,16'h0)};
      vt[11] = '{mk_st(1,1,0,22'h0FFFFF,8'h00,0,0,1,1,22'h000010,8'h11,16'h0,16'hCAFE),
                 mk_ex(1,1,8'hCA,0,3,0,3'b111,0,2,1,2'b01,19'h03FFF,0,16'h0)};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset strobes", 32'({rom_ce_n, ram_ce_n, ext_cs_n, mem_oe_n, mem_we_n, mem_be_n}), 32'h1FF);
      chk("reset acks", 32'({cpu_ack, lcd_vld, ldr_ack}), 32'h0);
      chk("reset rdata", 32'({cpu_rdata, lcd_rdata, ldr_rdata}), 32'h0);
      chk("reset mem_addr", 32'(mem_addr), 32'h0);
      chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_slot(vt[i].s, vt[i].e, $sformatf("vec%0d", i));

      // Extra slot_ena mid-access is ignored; request dropped after SETUP still completes.
      @(posedge clk); #1;
      bus_ph = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000003;
      rom_rdata = 16'h6611; slot_ena = 1'b1;
      @(posedge clk); #1;
      slot_ena = 1'b0; cpu_req = 1'b0;
      acks = 0; ack_pat = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         ack_pat[k-1] = cpu_ack;
         acks += int'(!rom_ce_n);
         if (k == 3) chk("drop-req rdata", 32'(cpu_rdata), 32'h66);
         if (k == 1) begin @(posedge clk); #1; slot_ena = 1'b1; end
         else if (k == 2) begin @(posedge clk); #1; slot_ena = 1'b0; end
      end
      chk("ignored slot_ena ack pattern", 32'(ack_pat), 32'h04);
      chk("ignored slot_ena rom_ce_n cycles", acks, 3);

      // Reset during STROBE aborts the access.
      @(posedge clk); #1;
      bus_ph = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h080020; cpu_wdata = 8'h99;
      slot_ena = 1'b1;
      @(posedge clk); #1;
      slot_ena = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("strobe we_n low", 32'(mem_we_n), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst mid-slot strobes", 32'({rom_ce_n, ram_ce_n, ext_cs_n, mem_oe_n, mem_we_n, mem_be_n}), 32'h1FF);
      chk("rst mid-slot ack", 32'(cpu_ack), 32'h0);
      rst = 1'b0; cpu_req = 1'b0;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         acks += int'(cpu_ack);
      end
      chk("rst mid-slot no late ack", acks, 0);

      // Randomized slots against the model.
      for (int i = 0; i < 60; i++) begin
         s.ph = 1'($urandom); s.creq = 1'($urandom); s.cwe = 1'($urandom);
         s.caddr = rand_addr(); s.cwd = 8'($urandom);
         s.lreq = 1'($urandom); s.laddr = rand_addr();
         s.dreq = 1'($urandom); s.dwe = 1'($urandom);
         s.daddr = rand_addr(); s.dwd = 8'($urandom);
         s.romd = 16'($urandom); s.ramd = 16'($urandom);
         run_slot(s, model(s), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
